flag_unit: RTL

- Producer side of the condition-flag interface. Computes Z/V/N from each ALU result, stages it through the post-EX pipeline and commits it to the architectural flag register.
- Drives the 3-bit flag bus read by the branch-condition block: bit 2 = Z, bit 1 = V, bit 0 = N.
- Raises a hazard when a branch in ID would read flags still in flight.

---
 rtl/flag_unit_pkg.sv | 17 +
 rtl/flag_unit_if.sv | 16 +
 rtl/flag_unit_calc.sv | 20 ++
 rtl/flag_unit.sv | 63 ++++++
 4 files changed

// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg: opcodes, flag indices, update masks and staged-entry type shared by the flag unit.
package flag_unit_pkg;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_MOV = 4'h7;
    localparam logic [3:0] OP_LW  = 4'h8, OP_SW  = 4'h9, OP_B   = 4'hA, OP_BR  = 4'hB;
    localparam logic [3:0] OP_J   = 4'hC, OP_JAL = 4'hD, OP_NOP = 4'hE, OP_HLT = 4'hF;
    localparam int FLAG_Z = 2, FLAG_V = 1, FLAG_N = 0;
    localparam logic [2:0] MASK_ZVN = 3'b111, MASK_Z = 3'b100, MASK_NONE = 3'b000;
    typedef struct packed {
        logic       valid;
        logic [2:0] mask;
        logic [2:0] flags;
    } flag_entry_t;
    function automatic logic [2:0] flag_merge(input logic [2:0] base, input flag_entry_t e);
        return e.valid ? (base & ~e.mask) | (e.flags & e.mask) : base;
    endfunction
endpackage

// File: rtl/flag_unit_if.sv
// flag_if: EX/ID-side signals into the flag unit and the flag bus back to branch logic.
interface flag_if #(parameter int DW = 16);
    logic          ex_valid;
    logic [3:0]    ex_op;
    logic [DW-1:0] alu_result;
    logic          alu_ovfl;
    logic          stall;
    logic          flush;
    logic          id_is_branch;
    logic [2:0]    F_out;
    logic          branch_hazard;
    modport master (output ex_valid, ex_op, alu_result, alu_ovfl, stall, flush, id_is_branch,
                    input F_out, branch_hazard);
    modport slave  (input ex_valid, ex_op, alu_result, alu_ovfl, stall, flush, id_is_branch,
                    output F_out, branch_hazard);
endinterface

// File: rtl/flag_unit_calc.sv
// flag_calc: per-opcode update mask and raw Z/V/N values for the EX result.
module flag_calc import flag_unit_pkg::*; #(
    parameter int DW = 16
) (
    input  logic [3:0]    ex_op,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_ovfl,
    output logic [2:0]    mask,
    output logic [2:0]    flags
);
    always_comb begin
        mask = (ex_op == OP_ADD || ex_op == OP_SUB) ? MASK_ZVN :
               (ex_op == OP_XOR || ex_op == OP_SLL || ex_op == OP_SRA || ex_op == OP_ROR) ? MASK_Z :
               MASK_NONE;
        flags = '0;
        flags[FLAG_Z] = alu_result == '0;
        flags[FLAG_V] = alu_ovfl;
        flags[FLAG_N] = alu_result[DW-1];
    end
endmodule

// File: rtl/flag_unit.sv
// flag_unit: stages EX flag updates for WB_DEPTH cycles, commits them under mask, flags branch hazards.
// Define FLAG_FWD_EN to forward in-flight flags onto F_out and suppress the hazard.
module flag_unit import flag_unit_pkg::*; #(
    parameter int WB_DEPTH = 1,
    parameter int DW       = 16
) (
    input logic   clk,
    input logic   rst,
    flag_if.slave bus
);
    logic [2:0] ex_mask, ex_flags;
    logic [2:0] f_reg_q, f_reg_d;
    flag_entry_t ex_entry;
    flag_entry_t [WB_DEPTH-1:0] stage_q, stage_d;

    flag_calc #(.DW(DW)) u_calc (
        .ex_op      (bus.ex_op),
        .alu_result (bus.alu_result),
        .alu_ovfl   (bus.alu_ovfl),
        .mask       (ex_mask),
        .flags      (ex_flags)
    );

    always_comb begin
        ex_entry = '{valid: bus.ex_valid & ~bus.flush & (ex_mask != MASK_NONE), mask: ex_mask, flags: ex_flags};
        stage_d = stage_q;
        f_reg_d = f_reg_q;
        if (!bus.stall) begin
            for (int i = WB_DEPTH - 1; i > 0; i--) stage_d[i] = stage_q[i-1];
            stage_d[0] = ex_entry;
            f_reg_d = flag_merge(f_reg_q, stage_q[WB_DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
            f_reg_q <= '0;
        end else begin
            stage_q <= stage_d;
            f_reg_q <= f_reg_d;
        end
    end

`ifdef FLAG_FWD_EN
    logic [2:0] fwd;
    // Overlay oldest (last stage) first so younger writers win their own bits.
    always_comb begin
        fwd = f_reg_q;
        for (int i = WB_DEPTH - 1; i >= 0; i--) fwd = flag_merge(fwd, stage_q[i]);
        bus.F_out = flag_merge(fwd, ex_entry);
        bus.branch_hazard = 1'b0;
    end
`else
    logic in_flight;
    always_comb begin
        in_flight = ex_entry.valid;
        for (int i = 0; i < WB_DEPTH; i++) in_flight = in_flight | stage_q[i].valid;
        bus.F_out = f_reg_q;
        bus.branch_hazard = bus.id_is_branch & in_flight;
    end
`endif
endmodule
